// File: rtl/ddr_burst_master.sv
// Host-side DDR burst master: accepts single read/write commands, stages write data in an
// FWFT FIFO, issues one burst request to the DDR controller and reports completion.
module ddr_burst_master #(
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int WR_FIFO_DEPTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              calib_done,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [DDR_ADDR_WIDTH-1:0]         cmd_addr,
    input  logic [9:0]                        cmd_len,
    input  logic                              wr_push,
    input  logic [DDR_DATA_WIDTH-1:0]         wr_din,
    output logic                              wr_full,
    output logic [$clog2(WR_FIFO_DEPTH):0]    wr_count,
    output logic [DDR_DATA_WIDTH-1:0]         rd_dout,
    output logic                              rd_dout_valid,
    output logic                              cmd_done,
    output logic                              err_ovf,
    output logic                              err_unf,
    output logic                              err_len,
    output logic                              rd_burst_req,
    output logic                              wr_burst_req,
    output logic [9:0]                        rd_burst_len,
    output logic [9:0]                        wr_burst_len,
    output logic [DDR_ADDR_WIDTH-1:0]         rd_burst_addr,
    output logic [DDR_ADDR_WIDTH-1:0]         wr_burst_addr,
    input  logic                              wr_burst_data_req,
    output logic [DDR_DATA_WIDTH-1:0]         wr_burst_data,
    input  logic                              rd_burst_data_valid,
    input  logic [DDR_DATA_WIDTH-1:0]         rd_burst_data,
    input  logic                              rd_burst_finish,
    input  logic                              wr_burst_finish
);

    localparam int PW = $clog2(WR_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [9:0] LEN_MAX = 10'(WR_FIFO_DEPTH);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_RUN  = 3'd2;
    localparam logic [2:0] WR_FILL = 3'd3;
    localparam logic [2:0] WR_REQ  = 3'd4;
    localparam logic [2:0] WR_RUN  = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]                state;
    logic [DDR_ADDR_WIDTH-1:0] addr_q;
    logic [9:0]                len_q;
    logic                      len_illegal;
    logic                      fill_ready;

    logic [DDR_DATA_WIDTH-1:0] mem [WR_FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic                      fifo_empty;
    logic                      pop;
    logic                      push_ok;

    assign cmd_ready   = (state == IDLE) && calib_done && !rst;
    assign len_illegal = (cmd_len == 10'd0) || (cmd_write && (cmd_len > LEN_MAX));
    assign fill_ready  = ({{(10-CW){1'b0}}, wr_count} >= len_q);

    assign rd_burst_req  = (state == RD_REQ);
    assign wr_burst_req  = (state == WR_REQ);
    assign cmd_done      = (state == DONE);
    assign rd_burst_addr = addr_q;
    assign wr_burst_addr = addr_q;
    assign rd_burst_len  = len_q;
    assign wr_burst_len  = len_q;

    // Command FSM; calib_done only gates acceptance, so a drop mid-command is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            err_len <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        if (len_illegal) begin
                            err_len <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= cmd_write ? WR_FILL : RD_REQ;
                        end
                    end
                end
                RD_REQ:  state <= RD_RUN;
                RD_RUN:  if (rd_burst_finish) state <= DONE;
                WR_FILL: if (fill_ready) state <= WR_REQ;
                WR_REQ:  state <= WR_RUN;
                WR_RUN:  if (wr_burst_finish) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dout       <= '0;
            rd_dout_valid <= 1'b0;
        end else begin
            rd_dout       <= rd_burst_data;
            rd_dout_valid <= rd_burst_data_valid;
        end
    end

    // A full FIFO still accepts a push when the controller pops in the same cycle.
    assign fifo_empty    = (wr_count == '0);
    assign wr_full       = (wr_count == CW'(WR_FIFO_DEPTH));
    assign pop           = wr_burst_data_req && !fifo_empty;
    assign push_ok       = wr_push && (!wr_full || pop);
    assign wr_burst_data = fifo_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_count <= '0;
            err_ovf  <= 1'b0;
            err_unf  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   wr_count <= wr_count + 1'b1;
                2'b01:   wr_count <= wr_count - 1'b1;
                default: wr_count <= wr_count;
            endcase
            if (wr_push && !push_ok) begin
                err_ovf <= 1'b1;
            end
            if (wr_burst_data_req && fifo_empty) begin
                err_unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_burst_master.sv
// Directed bench for ddr_burst_master; read and write data are tracked in scoreboard queues
// filled when words are driven and drained when the DUT presents them.
module tb_ddr_burst_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         calib_done;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [27:0]  cmd_addr;
    logic [9:0]   cmd_len;
    logic         wr_push;
    logic [127:0] wr_din;
    logic         wr_full;
    logic [4:0]   wr_count;
    logic [127:0] rd_dout;
    logic         rd_dout_valid;
    logic         cmd_done;
    logic         err_ovf;
    logic         err_unf;
    logic         err_len;
    logic         rd_burst_req;
    logic         wr_burst_req;
    logic [9:0]   rd_burst_len;
    logic [9:0]   wr_burst_len;
    logic [27:0]  rd_burst_addr;
    logic [27:0]  wr_burst_addr;
    logic         wr_burst_data_req;
    logic [127:0] wr_burst_data;
    logic         rd_burst_data_valid;
    logic [127:0] rd_burst_data;
    logic         rd_burst_finish;
    logic         wr_burst_finish;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] rdq[$];
    logic [127:0] wq[$];
    logic [127:0] word;

    ddr_burst_master dut (
        .clk(clk), .rst(rst), .calib_done(calib_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_push(wr_push), .wr_din(wr_din), .wr_full(wr_full), .wr_count(wr_count),
        .rd_dout(rd_dout), .rd_dout_valid(rd_dout_valid), .cmd_done(cmd_done),
        .err_ovf(err_ovf), .err_unf(err_unf), .err_len(err_len),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [27:0] a, input logic [9:0] l);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        #1;
        checkOutput("cmd_ready_offer", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic pushWord(input logic track);
        word    = {$urandom, $urandom, $urandom, $urandom};
        wr_push = 1'b1;
        wr_din  = word;
        if (track) wq.push_back(word);
        step();
        wr_push = 1'b0;
    endtask

    task automatic popWord(input string tag);
        wr_burst_data_req = 1'b1;
        #1;
        if (wq.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            checkOutput(tag, wr_burst_data, wq.pop_front());
        end
        step();
        wr_burst_data_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; calib_done = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_push = 1'b0; wr_din = '0;
        wr_burst_data_req = 1'b0; rd_burst_data_valid = 1'b0; rd_burst_data = '0;
        rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
        step();
        step();
        checkOutput("rst_cmd_ready", cmd_ready, 1'b0);
        checkOutput("rst_wr_count", wr_count, 5'd0);
        checkOutput("rst_wr_full", wr_full, 1'b0);
        checkOutput("rst_errs", {err_ovf, err_unf, err_len}, 3'b000);
        checkOutput("rst_rd_valid", rd_dout_valid, 1'b0);
        checkOutput("rst_rd_dout", rd_dout, 128'd0);
        checkOutput("rst_reqs", {rd_burst_req, wr_burst_req, cmd_done}, 3'b000);
        rst = 1'b0;
        step();
        checkOutput("idle_nocalib_ready", cmd_ready, 1'b0);
        calib_done = 1'b1;
        #1;
        checkOutput("idle_ready", cmd_ready, 1'b1);

        // Read burst of 8 words at 0x100; calib_done drops mid-burst without effect.
        applyStimulus(1'b0, 28'h100, 10'd8);
        checkOutput("rd_req_high", rd_burst_req, 1'b1);
        checkOutput("rd_req_len", rd_burst_len, 10'd8);
        checkOutput("rd_req_addr", rd_burst_addr, 28'h100);
        checkOutput("rd_req_no_wr", wr_burst_req, 1'b0);
        step();
        checkOutput("rd_req_oneshot", rd_burst_req, 1'b0);
        calib_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            word = {$urandom, $urandom, $urandom, $urandom};
            rd_burst_data_valid = 1'b1;
            rd_burst_data = word;
            rdq.push_back(word);
            step();
            checkOutput("rd_dout_valid", rd_dout_valid, 1'b1);
            checkOutput("rd_dout", rd_dout, rdq.pop_front());
        end
        rd_burst_data_valid = 1'b0;
        step();
        checkOutput("rd_dout_valid_low", rd_dout_valid, 1'b0);
        checkOutput("rd_addr_stable", rd_burst_addr, 28'h100);
        checkOutput("rd_len_stable", rd_burst_len, 10'd8);
        checkOutput("rd_run_no_done", cmd_done, 1'b0);
        rd_burst_finish = 1'b1;
        step();
        rd_burst_finish = 1'b0;
        checkOutput("rd_cmd_done", cmd_done, 1'b1);
        calib_done = 1'b1;
        step();
        checkOutput("rd_done_pulse", cmd_done, 1'b0);
        checkOutput("rd_back_idle", cmd_ready, 1'b1);

        // Write burst with 4 prefilled words.
        for (int i = 0; i < 4; i++) pushWord(1'b1);
        checkOutput("wr_prefill_count", wr_count, 5'd4);
        applyStimulus(1'b1, 28'h2000, 10'd4);
        checkOutput("wr_fill_noreq", wr_burst_req, 1'b0);
        step();
        checkOutput("wr_req_high", wr_burst_req, 1'b1);
        checkOutput("wr_req_len", wr_burst_len, 10'd4);
        checkOutput("wr_req_addr", wr_burst_addr, 28'h2000);
        checkOutput("wr_req_no_rd", rd_burst_req, 1'b0);
        step();
        checkOutput("wr_req_oneshot", wr_burst_req, 1'b0);
        for (int i = 0; i < 4; i++) popWord("wr_data_order");
        checkOutput("wr_drained", wr_count, 5'd0);
        checkOutput("wr_no_unf", err_unf, 1'b0);
        wr_burst_finish = 1'b1;
        step();
        wr_burst_finish = 1'b0;
        checkOutput("wr_cmd_done", cmd_done, 1'b1);
        checkOutput("wr_done_count", wr_count, 5'd0);
        step();

        // Write of 3 words with an empty FIFO must wait for all three pushes.
        applyStimulus(1'b1, 28'h3000, 10'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("fill_wait_noreq", wr_burst_req, 1'b0);
            pushWord(1'b1);
        end
        checkOutput("fill_count3", wr_count, 5'd3);
        checkOutput("fill_still_noreq", wr_burst_req, 1'b0);
        begin : wait_req
            int n = 0;
            while (!wr_burst_req && n < 8) begin
                step();
                n++;
            end
            checkOutput("fill_req_latency", n, 1);
        end
        step();
        for (int i = 0; i < 3; i++) popWord("fill_data_order");
        wr_burst_finish = 1'b1;
        step();
        wr_burst_finish = 1'b0;
        checkOutput("fill_cmd_done", cmd_done, 1'b1);
        step();

        // FIFO boundaries: overflow, push+pop when full, underflow.
        for (int i = 0; i < 16; i++) pushWord(1'b1);
        checkOutput("full_flag", wr_full, 1'b1);
        checkOutput("no_ovf_yet", err_ovf, 1'b0);
        pushWord(1'b0);
        checkOutput("ovf_set", err_ovf, 1'b1);
        checkOutput("ovf_count", wr_count, 5'd16);
        word = {$urandom, $urandom, $urandom, $urandom};
        wr_push = 1'b1;
        wr_din = word;
        wr_burst_data_req = 1'b1;
        #1;
        checkOutput("full_pushpop_head", wr_burst_data, wq.pop_front());
        wq.push_back(word);
        step();
        wr_push = 1'b0;
        wr_burst_data_req = 1'b0;
        checkOutput("full_pushpop_count", wr_count, 5'd16);
        checkOutput("full_pushpop_full", wr_full, 1'b1);
        for (int i = 0; i < 16; i++) popWord("drain_order");
        checkOutput("drain_count", wr_count, 5'd0);
        checkOutput("no_unf_yet", err_unf, 1'b0);
        wr_burst_data_req = 1'b1;
        #1;
        checkOutput("unf_data_zero", wr_burst_data, 128'd0);
        step();
        wr_burst_data_req = 1'b0;
        checkOutput("unf_set", err_unf, 1'b1);
        checkOutput("unf_count", wr_count, 5'd0);

        // Illegal lengths complete immediately with no burst.
        applyStimulus(1'b0, 28'h40, 10'd0);
        checkOutput("len0_err", err_len, 1'b1);
        checkOutput("len0_done", cmd_done, 1'b1);
        checkOutput("len0_noreq", {rd_burst_req, wr_burst_req}, 2'b00);
        step();
        checkOutput("len0_idle", cmd_ready, 1'b1);
        applyStimulus(1'b1, 28'h80, 10'd17);
        checkOutput("len17_done", cmd_done, 1'b1);
        checkOutput("len17_noreq", {rd_burst_req, wr_burst_req}, 2'b00);
        step();
        checkOutput("len17_idle_noreq", {rd_burst_req, wr_burst_req, cmd_done}, 3'b000);

        // Reset in the middle of a read burst.
        pushWord(1'b0);
        pushWord(1'b0);
        applyStimulus(1'b0, 28'h300, 10'd4);
        step();
        rd_burst_data_valid = 1'b1;
        rd_burst_data = {$urandom, $urandom, $urandom, $urandom};
        step();
        checkOutput("mid_rd_valid", rd_dout_valid, 1'b1);
        rst = 1'b1;
        step();
        rd_burst_data_valid = 1'b0;
        checkOutput("mid_rst_ready_held", cmd_ready, 1'b0);
        checkOutput("mid_rst_rd_valid", rd_dout_valid, 1'b0);
        checkOutput("mid_rst_rd_dout", rd_dout, 128'd0);
        checkOutput("mid_rst_errs", {err_ovf, err_unf, err_len}, 3'b000);
        checkOutput("mid_rst_fifo", {wr_full, wr_count}, 6'd0);
        checkOutput("mid_rst_addr", rd_burst_addr, 28'd0);
        checkOutput("mid_rst_len", rd_burst_len, 10'd0);
        checkOutput("mid_rst_reqs", {rd_burst_req, wr_burst_req, cmd_done}, 3'b000);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_ready", cmd_ready, 1'b1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
